nonogram_line_sched: RTL



---
 rtl/nonogram_line_sched.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/nonogram_line_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nonogram_line_sched: circular work queue that feeds line markers and options
// to the solver. Optional stall detect: LINE_SCHED_STALL_DETECT_EN. Rev 1.0
// ---------------------------------------------------------------------------
module nonogram_line_sched #(
  parameter int SIZE       = 3,
  parameter int DEPTH      = 64,
  parameter int CLOG_DEPTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [SIZE-1:0]       load_data,
  input  logic                  load_marker,
  input  logic                  load_last,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [SIZE-1:0]       issue_data,
  output logic                  issue_marker,
  input  logic                  push_valid,
  input  logic [SIZE-1:0]       push_data,
  input  logic                  progress,
  input  logic                  solved,
  output logic                  busy,
  output logic                  done,
  output logic                  stuck,
  output logic                  starved,
  output logic                  overflow,
  output logic [CLOG_DEPTH:0]   fill_level
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CLOG_DEPTH:0]   FULL_COUNT = DEPTH[CLOG_DEPTH:0];
  localparam logic [CLOG_DEPTH:0]   CNT_ONE    = {{CLOG_DEPTH{1'b0}}, 1'b1};
  localparam logic [CLOG_DEPTH-1:0] PTR_ONE    = {{(CLOG_DEPTH-1){1'b0}}, 1'b1};

  state_t                state;
  logic [SIZE:0]         mem [DEPTH];
  logic [CLOG_DEPTH-1:0] head;
  logic [CLOG_DEPTH-1:0] tail;
  logic [CLOG_DEPTH:0]   count;
  logic                  stuck_r;
  logic                  starved_r;
  logic                  overflow_r;

  logic          full;
  logic          empty;
  logic [SIZE:0] head_entry;
  logic          enter_load;
  logic          load_write;
  logic          run_active;
  logic          pop;
  logic          pop_marker;
  logic          push_ok;
  logic          push_drop;
  logic          wr_en;
  logic [SIZE:0] wr_entry;
  logic          stall_fire;

  assign full       = (count == FULL_COUNT);
  assign empty      = (count == '0);
  assign head_entry = mem[head];
  assign enter_load = load_start && ((state == S_IDLE) || (state == S_DONE));

  assign load_ready = (state == S_LOAD) && !full;
  assign load_write = load_valid && load_ready;

  // solved and starvation both end the run this cycle, so neither pops nor pushes.
  assign run_active  = (state == S_RUN) && !solved && !empty;
  // A head marker must not pop while the solver pushes: only one write port.
  assign issue_valid = run_active && !(head_entry[SIZE] && push_valid);
  assign pop         = issue_valid && issue_ready;
  assign pop_marker  = pop && head_entry[SIZE];
  assign push_ok     = run_active && push_valid && (!full || pop);
  assign push_drop   = run_active && push_valid && full && !pop;

  assign wr_en    = load_write || pop_marker || push_ok;
  assign wr_entry = load_write ? {load_marker, load_data} :
                    pop_marker ? head_entry :
                                 {1'b0, push_data};

  assign issue_data   = head_entry[SIZE-1:0];
  assign issue_marker = head_entry[SIZE];
  assign busy         = (state == S_LOAD) || (state == S_RUN);
  assign done         = (state == S_DONE);
  assign stuck        = stuck_r;
  assign starved      = starved_r;
  assign overflow     = overflow_r;
  assign fill_level   = count;

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[tail] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      stuck_r    <= 1'b0;
      starved_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en) begin
        tail <= tail + PTR_ONE;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      case (state)
        S_IDLE: begin
          if (load_start) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (load_write && load_last) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (solved) begin
            state <= S_DONE;
          end else if (empty) begin
            state     <= S_DONE;
            starved_r <= 1'b1;
          end else begin
            if (push_drop) begin
              overflow_r <= 1'b1;
            end
            if (stall_fire) begin
              stuck_r <= 1'b1;
              state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (load_start) begin
            state <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase

      // A fresh load wipes the queue; overrides any pointer update above.
      if (enter_load) begin
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        stuck_r    <= 1'b0;
        starved_r  <= 1'b0;
        overflow_r <= 1'b0;
      end
    end
  end

`ifdef LINE_SCHED_STALL_DETECT_EN
  // Two full sweeps of every line's marker with no newly known cell.
  localparam int STALL_LIMIT = 4 * SIZE;
  localparam int STALL_W     = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_LIMIT);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);
  localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);

  logic [STALL_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || enter_load) begin
      stall_cnt <= '0;
    end else if (state == S_RUN) begin
      if (progress) begin
        stall_cnt <= '0;
      end else if (pop_marker && (stall_cnt != STALL_MAX)) begin
        stall_cnt <= stall_cnt + STALL_ONE;
      end
    end
  end

  assign stall_fire = pop_marker && !progress && (stall_cnt >= STALL_LAST);
`else
  logic unused_progress;
  assign unused_progress = progress;
  assign stall_fire      = 1'b0;
`endif

endmodule
`default_nettype wire
